// File: rtl/alu_packet_parser.sv
// alu_packet_parser: byte-stream framer between UART RX and the ALU datapath.
// Parses a 4-byte header and packs the little-endian payload into operands.
module alu_packet_parser #(
    parameter int datawidth_p    = 8,
    parameter int opwidth_p      = 32,
    parameter int max_operands_p = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [datawidth_p-1:0] in_data_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [opwidth_p-1:0]   op_data_o,
    output logic [7:0]             op_opcode_o,
    output logic                   op_last_o,
    output logic                   op_valid_o,
    input  logic                   op_ready_i,
    output logic                   err_o
);

    localparam int bpo = opwidth_p / datawidth_p;
    localparam int cw  = (bpo > 1) ? $clog2(bpo) : 1;

    localparam logic [15:0]   min_len  = 16'(4 + 2 * bpo);
    localparam logic [15:0]   max_len  = 16'(4 + bpo * max_operands_p);
    localparam logic [15:0]   bpo_w    = 16'(bpo);
    localparam logic [cw-1:0] last_idx = cw'(bpo - 1);

    typedef enum logic [2:0] {
        OPC,
        RSV,
        LLO,
        LHI,
        DATA,
        DROP
    } state_t;

    state_t state;
    state_t state_n;

    logic [7:0]           opcode;
    logic [7:0]           len_lo;
    logic [15:0]          rem;
    logic [15:0]          rem_n;
    logic [cw-1:0]        cnt;
    logic [cw-1:0]        cnt_n;
    logic [opwidth_p-1:0] acc;
    logic [opwidth_p-1:0] word;
    logic [15:0]          len_w;
    logic [15:0]          body;
    logic                 opc_ok;
    logic                 pkt_ok;
    logic                 take;
    logic                 emit;
    logic                 err_n;

    // Stall only while an operand is waiting on the ALU.
    assign in_ready_o = rst_i && (!op_valid_o || op_ready_i);
    assign take       = in_valid_i && in_ready_o;

    assign len_w  = {in_data_i, len_lo};
    assign body   = len_w - 16'd4;
    assign opc_ok = (opcode >= 8'h10) && (opcode <= 8'h13);
    assign pkt_ok = opc_ok
                 && (len_w >= min_len)
                 && (len_w <= max_len)
                 && ((body % bpo_w) == 16'd0);

    always_comb begin
        word = acc;
        word[int'(cnt) * datawidth_p +: datawidth_p] = in_data_i;
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        cnt_n   = cnt;
        emit    = 1'b0;
        err_n   = 1'b0;
        if (take) begin
            unique case (state)
                OPC: state_n = RSV;
                RSV: state_n = LLO;
                LLO: state_n = LHI;
                LHI: begin
                    cnt_n = '0;
                    if (pkt_ok) begin
                        state_n = DATA;
                        rem_n   = body;
                    end else begin
                        err_n = 1'b1;
                        if (len_w > 16'd4) begin
                            state_n = DROP;
                            rem_n   = body;
                        end else begin
                            state_n = OPC;
                        end
                    end
                end
                DATA: begin
                    rem_n = rem - 16'd1;
                    if (cnt == last_idx) begin
                        cnt_n = '0;
                        emit  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                    if (rem == 16'd1) begin
                        state_n = OPC;
                    end
                end
                DROP: begin
                    rem_n = rem - 16'd1;
                    if (rem == 16'd1) begin
                        state_n = OPC;
                    end
                end
                default: state_n = OPC;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= OPC;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            opcode      <= '0;
            len_lo      <= '0;
            rem         <= '0;
            cnt         <= '0;
            acc         <= '0;
            op_data_o   <= '0;
            op_opcode_o <= '0;
            op_last_o   <= 1'b0;
            op_valid_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            rem   <= rem_n;
            cnt   <= cnt_n;
            err_o <= err_n;
            if (take && state == OPC) begin
                opcode <= in_data_i;
            end
            if (take && state == LLO) begin
                len_lo <= in_data_i;
            end
            if (take && state == DATA) begin
                acc <= word;
            end
            // A new operand can only land when the old one leaves.
            if (emit) begin
                op_data_o   <= word;
                op_opcode_o <= opcode;
                op_last_o   <= (rem == 16'd1);
                op_valid_o  <= 1'b1;
            end else if (op_ready_i) begin
                op_valid_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_packet_parser.sv
// tb_alu_packet_parser: table-driven and randomized checks of the framer
// against a packet-level reference model and operand scoreboard.
module tb_alu_packet_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_data;
    logic [7:0]  op_opcode;
    logic        op_last;
    logic        op_valid;
    logic        op_ready;
    logic        err;

    alu_packet_parser dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_data_o  (op_data),
        .op_opcode_o(op_opcode),
        .op_last_o  (op_last),
        .op_valid_o (op_valid),
        .op_ready_i (op_ready),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  o;
        logic        l;
    } op_t;

    typedef struct {
        logic [7:0] opc;
        int         len;
        bit         fixed;
        int         n_err;
        int         n_ops;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   err_seen = 0;
    int   exp_err = 0;
    int   ops_seen = 0;
    int   taken = 0;
    bit   rnd_rdy = 0;
    bit   gaps = 0;
    op_t  exp_q[$];
    logic [7:0] pkt[$];

    bit          held = 0;
    logic [31:0] hd;
    logic [7:0]  ho;
    logic        hl;
    op_t         e;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rnd_rdy) op_ready = ($urandom % 4) != 0;
    end

    // Monitor: handshakes are sampled half a cycle before the edge that takes them.
    always @(negedge clk) begin
        if (rst) begin
            if (in_valid && in_ready) taken++;
            if (err) err_seen++;
            if (held) begin
                chk("hold", {op_valid, op_last, op_opcode, op_data},
                    {1'b1, hl, ho, hd});
            end
            if (op_valid && op_ready) begin
                ops_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL op_unexpected: got %0h expected none",
                             op_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("op_data", op_data, e.d);
                    chk("op_opcode", op_opcode, e.o);
                    chk("op_last", op_last, e.l);
                end
            end
            held = op_valid && !op_ready;
            hd = op_data;
            ho = op_opcode;
            hl = op_last;
        end else begin
            held = 0;
        end
    end

    task automatic build_pkt(input logic [7:0] opc, input int len,
                             input bit fixed);
        int n;
        logic [15:0] l16;
        l16 = 16'(len);
        pkt.delete();
        pkt.push_back(opc);
        pkt.push_back(8'($urandom));
        pkt.push_back(l16[7:0]);
        pkt.push_back(l16[15:8]);
        n = (len > 4) ? len - 4 : 0;
        for (int i = 0; i < n; i++) begin
            if (fixed) pkt.push_back((i % 4 == 0) ? 8'(i / 4 + 1) : 8'h00);
            else       pkt.push_back(8'($urandom));
        end
    endtask

    // Reference model: whole-packet view of the framing rules.
    task automatic model_pkt();
        int   len;
        int   nops;
        logic [7:0] op;
        logic [31:0] w;
        bit   ok;
        op  = pkt[0];
        len = int'({pkt[3], pkt[2]});
        ok  = (op >= 8'h10) && (op <= 8'h13) && (len >= 12)
           && (len <= 68) && ((len - 4) % 4 == 0);
        if (!ok) begin
            exp_err++;
        end else begin
            nops = (len - 4) / 4;
            for (int k = 0; k < nops; k++) begin
                w = {pkt[4 + 4*k + 3], pkt[4 + 4*k + 2],
                     pkt[4 + 4*k + 1], pkt[4 + 4*k]};
                exp_q.push_back('{w, op, k == nops - 1});
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        if (gaps) begin
            repeat ($urandom % 3) begin
                @(posedge clk);
                #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 500);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pkt();
        for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i]);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin #500000; $display("FAIL watchdog: got timeout expected finish"); $fatal(1); end

    vec_t vt[14];

    initial begin
        int e0;
        int o0;
        int t0;
        vt = '{
            '{8'h10, 12, 1'b1, 0, 2},
            '{8'h7F, 12, 1'b0, 1, 0},
            '{8'h11, 12, 1'b0, 0, 2},
            '{8'h11, 10, 1'b0, 1, 0},
            '{8'h12,  3, 1'b0, 1, 0},
            '{8'h13, 16, 1'b0, 0, 3},
            '{8'h10, 68, 1'b0, 0, 16},
            '{8'h10, 72, 1'b0, 1, 0},
            '{8'h12,  4, 1'b0, 1, 0},
            '{8'h13,  8, 1'b0, 1, 0},
            '{8'h10, 13, 1'b0, 1, 0},
            '{8'h14, 12, 1'b0, 1, 0},
            '{8'h0F, 12, 1'b0, 1, 0},
            '{8'h11, 20, 1'b1, 0, 4}
        };
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        op_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_data", op_data, 0);
        chk("rst_op_opcode", op_opcode, 0);
        chk("rst_op_last", op_last, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", in_ready, 1);

        op_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            e0 = err_seen;
            o0 = ops_seen;
            build_pkt(vt[i].opc, vt[i].len, vt[i].fixed);
            model_pkt();
            send_pkt();
            drain();
            chk($sformatf("vec%0d_err", i), 64'(err_seen - e0),
                64'(vt[i].n_err));
            chk($sformatf("vec%0d_ops", i), 64'(ops_seen - o0),
                64'(vt[i].n_ops));
        end

        // Backpressure: first operand stalls, input must stop behind it.
        op_ready = 1'b0;
        t0 = taken;
        o0 = ops_seen;
        build_pkt(8'h10, 12, 1'b1);
        model_pkt();
        fork
            send_pkt();
            begin
                int n = 0;
                while (!op_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_valid", op_valid, 1);
                repeat (20) @(negedge clk);
                chk("bp_data", op_data, 32'h1);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_taken_lt12", 64'(taken - t0 < 12), 64'd1);
                @(posedge clk);
                #1;
                op_ready = 1'b1;
            end
        join
        drain();
        chk("bp_ops", 64'(ops_seen - o0), 64'd2);
        chk("bp_taken", 64'(taken - t0), 64'd12);

        // Reset after six payload bytes; one operand already delivered.
        pkt = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00,
                8'h00, 8'h00, 8'h02, 8'h00};
        exp_q.push_back('{32'h1, 8'h10, 1'b0});
        e0 = err_seen;
        send_pkt();
        drain();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_op_valid", op_valid, 0);
        chk("mid_rst_op_data", op_data, 0);
        chk("mid_rst_op_opcode", op_opcode, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        build_pkt(8'h12, 16, 1'b0);
        model_pkt();
        send_pkt();
        drain();
        chk("mid_rst_no_err", 64'(err_seen - e0), 64'd0);

        // Randomized packets, random ready and input gaps.
        rnd_rdy = 1;
        gaps    = 1;
        for (int p = 0; p < 25; p++) begin
            int r;
            int len;
            logic [7:0] opc;
            r = int'($urandom % 8);
            opc = (r < 6) ? 8'(8'h10 + r % 4) : 8'($urandom);
            r = int'($urandom % 10);
            if (r < 7)       len = 4 + 4 * (2 + int'($urandom % 15));
            else if (r == 7) len = int'($urandom % 12);
            else if (r == 8) len = 4 + 4 * (17 + int'($urandom % 2));
            else             len = 13 + int'($urandom % 20);
            build_pkt(opc, len, 1'b0);
            model_pkt();
            send_pkt();
        end
        drain();
        rnd_rdy = 0;
        chk("err_total", 64'(err_seen), 64'(exp_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
